// File: rtl/mips_mem_responder_if.sv
// Core fetch/data port and boot loader port of the MIPS memory responder.
// master = core and loader side, slave = responder side.
interface mips_mem_responder_if;
  logic [31:0] IR_addr;
  logic [31:0] IR;
  logic        CEN;
  logic        WEN;
  logic        OEN;
  logic [6:0]  A;
  logic [31:0] Data2Mem;
  logic [31:0] ReadDataMem;
  logic        ld_valid;
  logic        ld_ready;
  logic        ld_sel;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;

  modport master (
    output IR_addr, CEN, WEN, OEN, A, Data2Mem,
    output ld_valid, ld_sel, ld_addr, ld_data, ld_last,
    input  IR, ReadDataMem, ld_ready
  );

  modport slave (
    input  IR_addr, CEN, WEN, OEN, A, Data2Mem,
    input  ld_valid, ld_sel, ld_addr, ld_data, ld_last,
    output IR, ReadDataMem, ld_ready
  );
endinterface

// File: rtl/mips_mem_responder.sv
// Instruction/data memory responder for the single-cycle MIPS core.
// Zero-fills dmem, takes a loader image, then serves the core.
module mips_mem_responder #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 128
) (
  input  logic clk,
  input  logic rst_n,
  mips_mem_responder_if.slave bus,
  output logic core_rst_n,
  output logic err
);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]  r_state;
  logic [6:0]  r_cnt;
  logic        r_core_rst_n;
  logic        r_err;
  logic [31:0] r_imem [IMEM_WORDS];
  logic [31:0] r_dmem [DMEM_WORDS];

  logic w_clr;
  logic w_load;
  logic w_run;
  logic w_ld_hs;
  logic w_ld_iwr;
  logic w_ld_dwr;
  logic w_ld_bad;
  logic w_ir_bad;
  logic w_rd;
  logic w_coll;
  logic w_cwr;

  assign w_clr  = r_state == S_CLEAR;
  assign w_load = r_state == S_LOAD;
  assign w_run  = r_state == S_RUN;

  assign w_ld_hs  = w_load && bus.ld_valid;
  assign w_ld_iwr = w_ld_hs && !bus.ld_sel;
  assign w_ld_dwr = w_ld_hs && bus.ld_sel
                    && !bus.ld_addr[7];
  assign w_ld_bad = w_ld_hs && bus.ld_sel
                    && bus.ld_addr[7];

  assign w_ir_bad = (|bus.IR_addr[1:0])
                    || (|bus.IR_addr[31:10]);

  assign w_rd   = w_run && !bus.CEN && !bus.OEN;
  assign w_coll = w_rd && !bus.WEN;
  assign w_cwr  = w_run && !bus.CEN
                  && !bus.WEN && bus.OEN;

  assign bus.ld_ready = w_load;
  assign core_rst_n   = r_core_rst_n;
  assign err          = r_err;

  // Bad fetches read back as sll $0 (all zero).
  assign bus.IR = w_ir_bad ? 32'd0
                  : r_imem[bus.IR_addr[9:2]];

  assign bus.ReadDataMem = w_rd ? r_dmem[bus.A]
                           : 32'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_CLEAR;
      r_cnt        <= 7'd0;
      r_core_rst_n <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      unique case (r_state)
        S_CLEAR: begin
          r_cnt <= r_cnt + 7'd1;
          if (r_cnt == 7'(DMEM_WORDS - 1))
            r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (w_ld_hs && bus.ld_last) begin
            r_state      <= S_RUN;
            r_core_rst_n <= 1'b1;
          end
        end
        S_RUN: ;
        default: r_state <= S_CLEAR;
      endcase
      if (w_ld_bad || (w_run && (w_ir_bad || w_coll)))
        r_err <= 1'b1;
    end
  end

  // Single dmem write port; sources are exclusive by state.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      unique case (1'b1)
        w_clr:    r_dmem[r_cnt] <= 32'd0;
        w_ld_dwr: r_dmem[bus.ld_addr[6:0]] <= bus.ld_data;
        w_cwr:    r_dmem[bus.A] <= bus.Data2Mem;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_ld_iwr)
      r_imem[bus.ld_addr] <= bus.ld_data;
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench for mips_mem_responder.
// Expectations are queued at drive time and popped at sample time.
module tb_mips_mem_responder;

  logic clk = 1'b0;
  logic rst_n;
  logic core_rst_n;
  logic err;

  always #5 clk = ~clk;

  mips_mem_responder_if bus ();

  mips_mem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .err        (err)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag,
                      input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic pop_cmp(input logic [31:0] got);
    exp_t x;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_empty: got %h want entry", got);
    end else begin
      x = sb.pop_front();
      chk(x.tag, got, x.exp);
    end
  endtask

  task automatic idle();
    bus.CEN      = 1'b1;
    bus.WEN      = 1'b1;
    bus.OEN      = 1'b1;
    bus.A        = 7'd0;
    bus.Data2Mem = 32'd0;
    bus.ld_valid = 1'b0;
    bus.ld_sel   = 1'b0;
    bus.ld_addr  = 8'd0;
    bus.ld_data  = 32'd0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a,
                    input logic [31:0] e,
                    input string tag);
    @(negedge clk);
    bus.CEN = 1'b0;
    bus.WEN = 1'b1;
    bus.OEN = 1'b0;
    bus.A   = a;
    push(tag, e);
    #1;
    pop_cmp(bus.ReadDataMem);
  endtask

  task automatic fetch(input logic [31:0] a,
                       input logic [31:0] e,
                       input string tag);
    @(negedge clk);
    bus.IR_addr = a;
    push(tag, e);
    #1;
    pop_cmp(bus.IR);
  endtask

  // Leaves the caller just after the handshake edge.
  task automatic ld_word(input logic sel,
                         input logic [7:0] a,
                         input logic [31:0] d,
                         input logic last);
    logic hs;
    logic rdy;
    hs = 1'b0;
    @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_sel   = sel;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    bus.ld_last  = last;
    for (int i = 0; i < 20 && !hs; i++) begin
      rdy = bus.ld_ready;
      @(posedge clk);
      if (rdy) hs = 1'b1;
      else @(negedge clk);
    end
    #1;
    chk("ld_hs", {31'd0, hs}, 32'd1);
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.ld_ready) break;
    end
    chk(tag, n, 32'd128);
  endtask

  initial begin
    idle();
    bus.IR_addr = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus.ld_ready}, 32'd0);
    chk("rst_core", {31'd0, core_rst_n}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    rst_n = 1'b1;
    wait_clear("clr_len");

    ld_word(1'b0, 8'd0, 32'h2008_0005, 1'b0);
    ld_word(1'b0, 8'd1, 32'hAC08_0003, 1'b0);
    chk("core_hold", {31'd0, core_rst_n}, 32'd0);
    ld_word(1'b1, 8'd3, 32'hDEAD_BEEF, 1'b1);
    chk("core_up", {31'd0, core_rst_n}, 32'd1);
    chk("ready_run", {31'd0, bus.ld_ready}, 32'd0);
    @(negedge clk);
    idle();
    chk("load_err", {31'd0, err}, 32'd0);

    fetch(32'd4, 32'hAC08_0003, "fetch_w1");
    fetch(32'd0, 32'h2008_0005, "fetch_w0");

    for (int i = 0; i < 128; i++)
      rd(7'(i), (i == 3) ? 32'hDEAD_BEEF : 32'd0,
         "dmem_init");

    @(negedge clk);
    bus.CEN      = 1'b0;
    bus.WEN      = 1'b0;
    bus.OEN      = 1'b1;
    bus.A        = 7'd9;
    bus.Data2Mem = 32'h1234_5678;
    #1;
    chk("wr_cyc_rd", bus.ReadDataMem, 32'd0);
    rd(7'd9, 32'h1234_5678, "wr_then_rd");
    chk("wr_err", {31'd0, err}, 32'd0);

    @(negedge clk);
    bus.CEN      = 1'b0;
    bus.WEN      = 1'b0;
    bus.OEN      = 1'b0;
    bus.A        = 7'd3;
    bus.Data2Mem = 32'h5555_5555;
    push("coll_rd", 32'hDEAD_BEEF);
    #1;
    pop_cmp(bus.ReadDataMem);
    @(posedge clk);
    #1;
    chk("coll_err", {31'd0, err}, 32'd1);
    rd(7'd3, 32'hDEAD_BEEF, "coll_keep");

    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_core", {31'd0, core_rst_n}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("clr_len2");
    ld_word(1'b1, 8'd200, 32'hCAFE_F00D, 1'b1);
    chk("bad_ld_err", {31'd0, err}, 32'd1);
    chk("bad_ld_core", {31'd0, core_rst_n}, 32'd1);
    @(negedge clk);
    idle();
    rd(7'd9, 32'd0, "reclr_9");
    rd(7'd72, 32'd0, "drop_72");
    rd(7'd3, 32'd0, "reclr_3");
    fetch(32'd4, 32'hAC08_0003, "imem_keep");

    @(negedge clk);
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_clear("clr_len3");
    ld_word(1'b0, 8'd2, 32'h0000_0020, 1'b1);
    @(negedge clk);
    idle();
    chk("pre_fetch_err", {31'd0, err}, 32'd0);
    fetch(32'h400, 32'd0, "fetch_oob");
    @(posedge clk);
    #1;
    chk("fetch_err", {31'd0, err}, 32'd1);
    fetch(32'd8, 32'h0000_0020, "fetch_new");
    fetch(32'd5, 32'd0, "fetch_misal");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_mem_responder.md
# mips_mem_responder

Memory-side responder for the single-cycle MIPS core: owns the instruction memory and the 128-word data memory and answers the core's IR_addr/IR fetch port and its CEN/WEN/OEN/A/Data2Mem/ReadDataMem data port. A boot sequencer zero-fills data memory, then accepts program and data words from an external loader over a valid/ready handshake. It holds the core in reset until loading completes and then serves the core's accesses every cycle.

## Interface
- IMEM_WORDS, 256, instruction memory depth in words; fetch index is IR_addr[9:2].
- DMEM_WORDS, 128, data memory depth in words; indexed directly by A.
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- IR_addr  input  32  core fetch byte address.
- IR  output  32  instruction word at IR_addr.
- CEN  input  1  chip enable, active low.
- WEN  input  1  write enable, active low.
- OEN  input  1  output enable, active low.
- A  input  7  data word address.
- Data2Mem  input  32  store data.
- ReadDataMem  output  32  load data.
- ld_valid  input  1  loader word valid.
- ld_ready  output  1  responder accepts a loader word.
- ld_sel  input  1  0 = instruction memory, 1 = data memory.
- ld_addr  input  8  loader word index.
- ld_data  input  32  loader word.
- ld_last  input  1  marks the final loader word.
- core_rst_n  output  1  active-low reset to the core; registered.
- err  output  1  sticky protocol-error flag.

## Operation
- States: CLEAR, LOAD, RUN. On reset: CLEAR, clear counter = 0, ld_ready = 0, core_rst_n = 0, err = 0.
- CLEAR: each cycle writes 32'd0 to dmem[counter] and increments the counter. After the write at index DMEM_WORDS-1 the next state is LOAD. Instruction memory is not cleared.
- LOAD: ld_ready = 1.
  - A handshake (ld_valid && ld_ready at the edge) writes ld_data to imem[ld_addr] when ld_sel = 0, or to dmem[ld_addr[6:0]] when ld_sel = 1.
  - A data write with ld_addr[7] = 1 is dropped and sets err.
  - A handshake with ld_last = 1 writes its word, then the next state is RUN.
- RUN: ld_ready = 0; core_rst_n = 1; loader inputs are ignored.
- Fetch, in all states: IR = imem[IR_addr[9:2]], combinational. IR_addr[1:0] != 0 or IR_addr >= 4*IMEM_WORDS returns 32'd0 (sll $0 nop) and sets err (RUN only).
- Data read, in RUN: if CEN = 0 and OEN = 0, ReadDataMem = dmem[A], combinational from the array. Otherwise ReadDataMem = 32'd0.
- Data write, in RUN: if CEN = 0, WEN = 0 and OEN = 1, dmem[A] <= Data2Mem at the edge.
- Simultaneous WEN = 0 and OEN = 0: the read is served and the write is suppressed; err is set.
- Core-port writes outside RUN are ignored. The core is in reset then, so any such write is a bench error.
- A read of an address written in the same cycle returns the old contents. The new value is visible from the next cycle.
- err clears only on reset.

## Timing
- rst_n sampled low at edge E: from E+1, state = CLEAR and core_rst_n = 0.
- First rising edge with rst_n high (R) writes dmem[0]. Edges R..R+DMEM_WORDS-1 perform the clear. ld_ready rises after edge R+DMEM_WORDS-1, one cycle after the last clear.
- Loader: one word per cycle maximum. ld_valid may be held, and data must stay stable until the handshake.
- The last handshake at edge L gives state RUN and core_rst_n = 1 after L. The core's first fetch is evaluated in the cycle after L.
- Core data port: zero-latency reads (combinational), single-edge writes, matching the single-cycle core. No stall exists.
- Reset mid-LOAD or mid-RUN returns to CLEAR. Data memory is re-zeroed; instruction memory keeps its contents.

## Test plan
- Reset, then hold rst_n high: ld_ready = 0 for exactly 128 cycles, then 1. Every dmem word reads 0 after RUN.
- Load imem[0] = 32'h2008_0005, imem[1] = 32'hAC08_0003, dmem[3] = 32'hDEAD_BEEF, with the last word flagged. core_rst_n rises one cycle after the final handshake, and IR at IR_addr = 4 returns 32'hAC08_0003.
- In RUN, drive CEN = 0, WEN = 0, OEN = 1, A = 7'd9, Data2Mem = 32'h1234_5678. Next cycle, CEN = 0, OEN = 0, A = 9 returns 32'h1234_5678. In the write cycle itself, a read of A = 9 returns the old value 0.
- Loader data word at ld_addr = 8'd200: the word is dropped, err = 1, and the handshake still completes.
- CEN = 0, WEN = 0, OEN = 0 on A = 3: ReadDataMem = 32'hDEAD_BEEF, dmem[3] is unchanged, err = 1. Fetch at IR_addr = 32'h400 returns 0.
- Reset asserted mid-RUN after storing to dmem[9]: core_rst_n = 0 on the next cycle and dmem[9] = 0 after re-clear. imem[1] still returns 32'hAC08_0003 once the reload with only ld_last completes.
